seg7_latch_scheduler: RTL
=========================

Name: seg7_latch_scheduler

Overview:
- Sequences writes onto the shared 7-seg bus and its six per-digit latch enables.
- Sits between the time core (bcd24 in {Ht,Ho,Mt,Mo,St,So} order) and the external digit latches.
- Only digits whose displayed code differs from the latched copy are written, plus a slow background refresh and an on-demand full rewrite.
- Requesting digits are served round-robin, one 3-cycle setup/strobe/hold write at a time.

Parameters:
REFRESH_TICKS, 60, clk cycles between background refresh requests; 0 disables refresh
SEG_ACTIVE_LOW, 0, 1 inverts the segment bus (common-anode)
LE_ACTIVE_HIGH, 1, 0 makes latch-enable pulses active-low

Ports:
clk  input  1  AC-derived logic clock, single clock domain
rst_n  input  1  asynchronous active-low reset
bcd24  input  24  {Ht,Ho,Mt,Mo,St,So}; nibble for digit i is bcd24[23-4i -: 4]
blank_mask  input  6  bit i=1 shows digit i blank (set-mode field flashing)
force_all  input  1  single-cycle request to rewrite all six digits
seg7_bus  output  7  {a,b,c,d,e,f,g}, registered
le  output  6  one-hot latch enables, registered, le[0]=Ht .. le[5]=So
busy  output  1  1 while a write is in progress (state != IDLE)

Behaviour:
- Digit code is 5 bits per digit: blank_mask[i] ? BLANK (5'h10) : {1'b0, nibble}.
- Shadow shown[i] (5b) holds the last latched code; reset value 5'h1F (invalid), so all digits are dirty after reset.
- pend[i] is the force flag. dirty[i] = (code[i] != shown[i]) | pend[i].
- Encoding, active-high before polarity:
  - 0..9 standard (0=1111110, 1=0110000, 7=1110000, 8=1111111).
  - 10..15 = 0000001 ('-').
  - BLANK = 0000000.
  - Apply SEG_ACTIVE_LOW inversion last.
- FSM states IDLE, SETUP, STROBE, HOLD.
  - IDLE: if any dirty, at the edge select digit s; register cur=code[s]; seg7_bus<=enc(cur); le<=OFF; go to SETUP. Otherwise stay.
  - SETUP -> STROBE: le[s]<=ON, others OFF; shown[s]<=cur; pend[s] cleared.
  - STROBE -> HOLD: le<=OFF; bus unchanged.
  - HOLD: if any dirty, select the next digit and load the bus as in IDLE, going to SETUP. Otherwise go to IDLE.
- Each write is exactly 3 cycles with the bus stable for all 3 and LE active for exactly 1. The bus holds its last value in IDLE.
- Latency: a change visible at IDLE edge k gives an LE pulse during cycle k+1..k+2 (second edge after k).
- Selection: first dirty digit searching ascending from (last+1) mod 6. last is the most recently served digit; reset value 5, so the first service is digit 0.
- cur is captured at selection. bcd24/blank_mask changes mid-write do not disturb the bus. The digit stays dirty and is rewritten later.
- Refresh counter:
  - Free-running 0..REFRESH_TICKS-1, independent of the FSM.
  - At terminal count, set pend[rptr] and advance rptr mod 6 (reset 0).
- force_all sets all pend bits.
- Same-edge set and clear of a pend bit: set wins.
- Reset, asynchronous and immediate, including mid-write:
  - state=IDLE; le=LE_OFF; seg7_bus=enc(BLANK) with polarity applied.
  - busy=0; shown=all 5'h1F; pend=0; last=5; refresh counter=0; rptr=0.
- After release, all six digits are rewritten in order 0..5 in 18 cycles.

Test Plan:
1. Release reset with bcd24=24'h123456, mask 0, REFRESH_TICKS=0 -> le pulses 000001,000010,...,100000 on cycles 2,5,8,11,14,17 after the first edge. Bus = enc(1..6) respectively (e.g. 6 -> 1011111); busy falls after 18 cycles.
2. Idle, change bcd24 to 24'h123457 -> exactly one write: le=100000 pulse, bus=1110000; no other le activity.
3. blank_mask=6'b000011 -> writes to digits 0 and 1 with bus=0000000. Clearing the mask rewrites them with enc(1) and enc(2).
4. last=3 idle; change digits 0, 2, 4 in the same cycle -> service order 4, 0, 2, back-to-back (9 cycles, busy continuous).
5. REFRESH_TICKS=8, static input -> one write every 8 cycles, digit rotating 0,1,...,5,0. force_all pulse while idle -> six consecutive writes starting at (last+1) mod 6.
6. Assert rst_n low during STROBE -> le=000000 and bus=0000000 in the same cycle without a clock edge. After release, full 0..5 rewrite per test 1.

Source files
------------

// File: rtl/seg7_latch_scheduler.sv
// seg7_latch_scheduler
//   Schedules writes of six BCD digits onto a shared 7-segment bus with one
//   latch enable per digit. Only digits whose displayed code differs from the
//   latched copy are written. A slow background refresh and an on-demand full
//   rewrite are also supported. Each write takes three cycles: setup, strobe
//   and hold.
//
// Ports
//   clk        : logic clock (single domain)
//   rst_n      : asynchronous active-low reset
//   bcd24      : {Ht,Ho,Mt,Mo,St,So}; digit i nibble is bcd24[23-4i -: 4]
//   blank_mask : bit i=1 blanks digit i
//   force_all  : single-cycle request to rewrite all six digits
//   seg7_bus   : registered {a,b,c,d,e,f,g} segment bus
//   le         : registered one-hot latch enables, le[0]=Ht .. le[5]=So
//   busy       : high while a write is in progress
module seg7_latch_scheduler #(
    parameter int unsigned REFRESH_TICKS  = 60,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          LE_ACTIVE_HIGH = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd24,
    input  logic [5:0]  blank_mask,
    input  logic        force_all,
    output logic [6:0]  seg7_bus,
    output logic [5:0]  le,
    output logic        busy
);

    localparam logic [4:0]    BLANK     = 5'h10;
    localparam logic [4:0]    INVALID   = 5'h1F;
    localparam logic [5:0]    LE_OFF    = LE_ACTIVE_HIGH ? 6'b000000 : 6'b111111;
    localparam logic [6:0]    SEG_POL   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam int unsigned   CW        = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam int unsigned   RT_LAST   = (REFRESH_TICKS > 0) ? REFRESH_TICKS - 1 : 0;
    localparam logic [CW-1:0] RCNT_LAST = RT_LAST[CW-1:0];

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t        state, state_next;
    logic [4:0]    code  [6];
    logic [4:0]    shown [6];
    logic [5:0]    dirty;
    logic [5:0]    pend, pend_next;
    logic [4:0]    cur;
    logic [2:0]    digit;
    logic [2:0]    last;
    logic [2:0]    sel_idx;
    logic          any_dirty;
    logic          found;
    logic [3:0]    cand;
    logic          load;
    logic          refresh_hit;
    logic [CW-1:0] rcnt;
    logic [2:0]    rptr;

    // Segment encoding {a..g}, polarity applied last.
    function automatic logic [6:0] enc(input logic [4:0] c);
        logic [6:0] s;
        if (c[4]) begin
            s = 7'b0000000;
        end else begin
            case (c[3:0])
                4'd0:    s = 7'b1111110;
                4'd1:    s = 7'b0110000;
                4'd2:    s = 7'b1101101;
                4'd3:    s = 7'b1111001;
                4'd4:    s = 7'b0110011;
                4'd5:    s = 7'b1011011;
                4'd6:    s = 7'b1011111;
                4'd7:    s = 7'b1110000;
                4'd8:    s = 7'b1111111;
                4'd9:    s = 7'b1111011;
                default: s = 7'b0000001;
            endcase
        end
        return s ^ SEG_POL;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 6; i++) begin
            code[i]  = blank_mask[i] ? BLANK : {1'b0, bcd24[23-4*i -: 4]};
            dirty[i] = (code[i] != shown[i]) | pend[i];
        end
    end

    // Round-robin pick: first dirty digit searching upward from last+1.
    always_comb begin
        sel_idx = last;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= 6; k++) begin
            cand = {1'b0, last} + 4'(k);
            if (cand >= 4'd6) cand = cand - 4'd6;
            if (!found && dirty[cand[2:0]]) begin
                found   = 1'b1;
                sel_idx = cand[2:0];
            end
        end
        any_dirty = |dirty;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_dirty) state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  state_next = HOLD;
            HOLD:    state_next = any_dirty ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy = (state != IDLE);
        load = ((state == IDLE) || (state == HOLD)) && any_dirty;
    end

    assign refresh_hit = (REFRESH_TICKS != 0) && (rcnt == RCNT_LAST);

    // Refresh and force both set pend after the strobe clear, so a set wins.
    always_comb begin
        pend_next = pend;
        if (state == SETUP) pend_next[digit] = 1'b0;
        if (refresh_hit)    pend_next[rptr]  = 1'b1;
        if (force_all)      pend_next        = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg7_bus <= enc(BLANK);
            le       <= LE_OFF;
            cur      <= BLANK;
            digit    <= '0;
            last     <= 3'd5;
            pend     <= '0;
            for (int unsigned i = 0; i < 6; i++) shown[i] <= INVALID;
        end else begin
            pend <= pend_next;
            if (load) begin
                cur      <= code[sel_idx];
                digit    <= sel_idx;
                last     <= sel_idx;
                seg7_bus <= enc(code[sel_idx]);
                le       <= LE_OFF;
            end else if (state == SETUP) begin
                le           <= LE_OFF ^ (6'b000001 << digit);
                shown[digit] <= cur;
            end else if (state == STROBE) begin
                le <= LE_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            rptr <= '0;
        end else if (refresh_hit) begin
            rcnt <= '0;
            rptr <= (rptr == 3'd5) ? 3'd0 : rptr + 3'd1;
        end else if (REFRESH_TICKS != 0) begin
            rcnt <= rcnt + 1'b1;
        end
    end

endmodule
